// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment patterns, tracker states and the segment-to-BCD decoder.
package seg_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;
   typedef struct packed {
      logic       valid;
      logic [3:0] digit;
   } bcd_t;
   function automatic bcd_t seg_to_bcd(input logic [6:0] seg);
      bcd_t r;
      r = '{valid: 1'b0, digit: 4'd0};
      for (int i = 0; i < 10; i++)
         if (seg == SEG_DIGIT[i]) r = '{valid: 1'b1, digit: 4'(i)};
      return r;
   endfunction
endpackage

// File: rtl/seg_stabilizer.sv
// seg_stabilizer: synchronizes the segment bus and flags each newly settled pattern once.
module seg_stabilizer
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [6:0] seg_in,
   output logic [6:0] p,
   output logic       accept
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   logic [6:0]    sync1, sync2, last;
   logic [CW-1:0] stab_cnt;
   assign p = ACTIVE_LOW ? ~sync2 : sync2;
   assign accept = ena && stab_cnt == CW'(STABLE_CYCLES - 1) && p != last;
   // Stability restarts whenever the next sample differs from the current pattern.
   always_ff @(posedge clk)
      if (!rst_n) begin
         sync1    <= '0;
         sync2    <= '0;
         last     <= SEG_BLANK;
         stab_cnt <= '0;
      end else begin
         sync1 <= seg_in;
         sync2 <= sync1;
         if (accept) last <= p;
         if (!ena || sync1 != sync2) stab_cnt <= '0;
         else if (stab_cnt != CW'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 1'b1;
      end
endmodule

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: decodes a settled segment bus, checks digit succession, times digit ticks.
module seven_segment_reader
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int PERIOD_W      = 24,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [6:0]          seg_in,
   output logic [3:0]          digit_out,
   output logic                digit_valid,
   output logic                pattern_err,
   output logic                seq_err,
   output logic [PERIOD_W-1:0] period_out,
   output logic                period_valid
);
   logic [6:0]          p;
   logic                accept;
   state_t              state;
   bcd_t                dec;
   logic [PERIOD_W-1:0] cnt, cnt_inc;
   logic [3:0]          next_digit;
   seg_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_stab (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .p(p), .accept(accept)
   );
   assign dec        = seg_to_bcd(p);
   assign cnt_inc    = &cnt ? cnt : cnt + 1'b1;
   assign next_digit = digit_out == 4'd9 ? 4'd0 : digit_out + 4'd1;
   // The reported period includes the accept cycle itself, so it equals the accept-to-accept distance.
   always_ff @(posedge clk)
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         digit_out    <= '0;
         digit_valid  <= 1'b0;
         pattern_err  <= 1'b0;
         seq_err      <= 1'b0;
         period_out   <= '0;
         period_valid <= 1'b0;
      end else begin
         digit_valid  <= 1'b0;
         pattern_err  <= 1'b0;
         seq_err      <= 1'b0;
         period_valid <= 1'b0;
         if (ena && state != IDLE) cnt <= cnt_inc;
         if (accept && dec.valid) begin
            digit_out   <= dec.digit;
            digit_valid <= 1'b1;
            cnt         <= '0;
            if (state == IDLE) state <= FIRST;
            else begin
               seq_err      <= dec.digit != next_digit;
               period_out   <= cnt_inc;
               period_valid <= 1'b1;
               state        <= TRACK;
            end
         end else if (accept && p != SEG_BLANK) begin
            pattern_err <= 1'b1;
            state       <= IDLE;
         end
      end
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed scenarios against hand-computed pulse counts, digits and periods.
module tb_seven_segment_reader;
   logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
   logic [6:0]  seg_in = 7'h00;
   logic [3:0]  digit_out, d4_digit;
   logic        digit_valid, pattern_err, seq_err, period_valid;
   logic        d4_dv, d4_pe, d4_se, d4_pv;
   logic [23:0] period_out;
   logic [3:0]  d4_period;
   int passed = 0, total = 0;
   int cyc = 0, n_dv = 0, n_pe = 0, n_se = 0, n_pv = 0, excl_bad = 0;
   int last_per = 0, last_per4 = 0, dv_cyc = 0;
   int b_dv, b_pe, b_se, b_pv, c0;

   seven_segment_reader dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .digit_out(digit_out),
      .digit_valid(digit_valid), .pattern_err(pattern_err), .seq_err(seq_err),
      .period_out(period_out), .period_valid(period_valid)
   );
   seven_segment_reader #(.PERIOD_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .digit_out(d4_digit),
      .digit_valid(d4_dv), .pattern_err(d4_pe), .seq_err(d4_se),
      .period_out(d4_period), .period_valid(d4_pv)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (digit_valid) begin n_dv++; dv_cyc = cyc; end
      if (pattern_err) n_pe++;
      if (seq_err) n_se++;
      if (period_valid) begin n_pv++; last_per = int'(period_out); end
      if (d4_pv) last_per4 = int'(d4_period);
      if ((pattern_err && digit_valid) || (seq_err && !digit_valid) || (period_valid && !digit_valid))
         excl_bad++;
   end

   task automatic hold(input logic [6:0] pat, input int n);
      seg_in = pat;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mark();
      b_dv = n_dv; b_pe = n_pe; b_se = n_se; b_pv = n_pv;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      seg_in = 7'h00;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if ({digit_out, digit_valid, pattern_err, seq_err, period_valid} !== 8'h00)
         $display("FAIL reset_outs: got %h want 00", {digit_out, digit_valid, pattern_err, seq_err, period_valid}); else passed++;
      total++; if (period_out !== 24'd0) $display("FAIL reset_period: got %0d want 0", period_out); else passed++;
      mark();
      c0 = cyc;
      rst_n = 1'b1;
      hold(7'h3F, 10);
      total++; if (n_dv - b_dv !== 1) $display("FAIL t1_dv_count: got %0d want 1", n_dv - b_dv); else passed++;
      total++; if (dv_cyc - c0 !== 6) $display("FAIL t1_latency: got %0d want 6", dv_cyc - c0); else passed++;
      total++; if (digit_out !== 4'd0) $display("FAIL t1_digit: got %0d want 0", digit_out); else passed++;
      total++; if (n_se - b_se + n_pv - b_pv !== 0) $display("FAIL t1_no_se_pv: got %0d want 0", n_se - b_se + n_pv - b_pv); else passed++;
   endtask

   task automatic test_sequence();
      do_reset();
      mark();
      hold(7'h3F, 100);
      hold(7'h06, 100);
      hold(7'h5B, 100);
      total++; if (n_dv - b_dv !== 3) $display("FAIL t2_dv_count: got %0d want 3", n_dv - b_dv); else passed++;
      total++; if (n_pv - b_pv !== 2) $display("FAIL t2_pv_count: got %0d want 2", n_pv - b_pv); else passed++;
      total++; if (last_per !== 100) $display("FAIL t2_period: got %0d want 100", last_per); else passed++;
      total++; if (n_se - b_se !== 0) $display("FAIL t2_seq_err: got %0d want 0", n_se - b_se); else passed++;
      total++; if (digit_out !== 4'd2) $display("FAIL t2_digit: got %0d want 2", digit_out); else passed++;
      total++; if (last_per4 !== 15) $display("FAIL t2_period_sat4: got %0d want 15", last_per4); else passed++;
   endtask

   task automatic test_wrap();
      mark();
      hold(7'h6F, 20);
      total++; if (n_se - b_se !== 1) $display("FAIL t3_2to9_se: got %0d want 1", n_se - b_se); else passed++;
      mark();
      hold(7'h3F, 20);
      total++; if (n_se - b_se !== 0) $display("FAIL t3_9to0_se: got %0d want 0", n_se - b_se); else passed++;
      total++; if (digit_out !== 4'd0) $display("FAIL t3_digit0: got %0d want 0", digit_out); else passed++;
      total++; if (last_per !== 20) $display("FAIL t3_period: got %0d want 20", last_per); else passed++;
      mark();
      hold(7'h5B, 20);
      total++; if (n_se - b_se !== 1) $display("FAIL t3_0to2_se: got %0d want 1", n_se - b_se); else passed++;
      total++; if (n_dv - b_dv !== 1) $display("FAIL t3_0to2_dv: got %0d want 1", n_dv - b_dv); else passed++;
   endtask

   task automatic test_glitch();
      hold(7'h06, 20);
      mark();
      hold(7'h7F, 3);
      hold(7'h06, 20);
      total++; if (n_dv - b_dv + n_pe - b_pe + n_se - b_se + n_pv - b_pv !== 0)
         $display("FAIL t4_glitch_pulses: got %0d want 0", n_dv - b_dv + n_pe - b_pe + n_se - b_se + n_pv - b_pv); else passed++;
      total++; if (digit_out !== 4'd1) $display("FAIL t4_digit: got %0d want 1", digit_out); else passed++;
   endtask

   task automatic test_pattern_err();
      mark();
      hold(7'h49, 20);
      total++; if (n_pe - b_pe !== 1) $display("FAIL t5_pe_count: got %0d want 1", n_pe - b_pe); else passed++;
      total++; if (n_dv - b_dv !== 0) $display("FAIL t5_no_dv: got %0d want 0", n_dv - b_dv); else passed++;
      total++; if (digit_out !== 4'd1) $display("FAIL t5_digit_held: got %0d want 1", digit_out); else passed++;
      mark();
      hold(7'h5B, 20);
      total++; if (n_dv - b_dv !== 1) $display("FAIL t5_restart_dv: got %0d want 1", n_dv - b_dv); else passed++;
      total++; if (n_pv - b_pv + n_se - b_se !== 0) $display("FAIL t5_restart_pv_se: got %0d want 0", n_pv - b_pv + n_se - b_se); else passed++;
      mark();
      hold(7'h4F, 20);
      total++; if (n_pv - b_pv !== 1) $display("FAIL t5_next_pv: got %0d want 1", n_pv - b_pv); else passed++;
      total++; if (n_se - b_se !== 0) $display("FAIL t5_next_se: got %0d want 0", n_se - b_se); else passed++;
   endtask

   task automatic test_ena_reset();
      mark();
      ena = 1'b0;
      hold(7'h66, 50);
      total++; if (n_dv - b_dv + n_pe - b_pe + n_pv - b_pv !== 0)
         $display("FAIL t6_ena_low_pulses: got %0d want 0", n_dv - b_dv + n_pe - b_pe + n_pv - b_pv); else passed++;
      total++; if (digit_out !== 4'd3) $display("FAIL t6_ena_low_digit: got %0d want 3", digit_out); else passed++;
      ena = 1'b1;
      hold(7'h66, 20);
      total++; if (n_dv - b_dv !== 1) $display("FAIL t6_reenable_dv: got %0d want 1", n_dv - b_dv); else passed++;
      total++; if (digit_out !== 4'd4) $display("FAIL t6_reenable_digit: got %0d want 4", digit_out); else passed++;
      total++; if (last_per !== 18) $display("FAIL t6_frozen_period: got %0d want 18", last_per); else passed++;
      hold(7'h66, 5);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++; if ({digit_out, digit_valid, pattern_err, seq_err, period_valid} !== 8'h00)
         $display("FAIL t6_reset_outs: got %h want 00", {digit_out, digit_valid, pattern_err, seq_err, period_valid}); else passed++;
      total++; if (period_out !== 24'd0) $display("FAIL t6_reset_period: got %0d want 0", period_out); else passed++;
      repeat (2) @(posedge clk);
      #1;
      mark();
      c0 = cyc;
      rst_n = 1'b1;
      hold(7'h3F, 20);
      total++; if (n_dv - b_dv !== 1) $display("FAIL t6_first_dv: got %0d want 1", n_dv - b_dv); else passed++;
      total++; if (dv_cyc - c0 !== 6) $display("FAIL t6_first_latency: got %0d want 6", dv_cyc - c0); else passed++;
      total++; if (n_pv - b_pv + n_se - b_se !== 0) $display("FAIL t6_first_pv_se: got %0d want 0", n_pv - b_pv + n_se - b_se); else passed++;
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_wrap();
      test_glitch();
      test_pattern_err();
      test_ena_reset();
      total++; if (excl_bad !== 0) $display("FAIL pulse_exclusivity: got %0d want 0", excl_bad); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
